// File: rtl/mdio_master.sv
// MDIO (IEEE 802.3 Clause 22) management master.
// Runs one read or write frame per accepted command. MDC is divided down from
// clk, and the MDIO pad is split into mdio_o/mdio_t/mdio_i for an external IOBUF.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame; cmd_ready high; mdc low, MDIO released and high
// PRE    | 32 preamble ones (skipped when PREAMBLE_EN = 0)
// HDR    | ST, OP, PHYAD, REGAD: 14 bits, always driven
// TA     | 2 turnaround bits; released on reads, second bit sampled
// DATA   | 16 data bits; driven on writes, sampled on reads
module mdio_master #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned PREAMBLE_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  // Phase counter counts down through the 2*CLK_DIV clk cycles of one bit.
  // PH_LAST marks bit start (mdc low); reaching PH_RISE on the next edge
  // raises mdc; zero is the last cycle of the bit.
  localparam int unsigned PH_W = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA
  } state_e;

  state_e          state_q;
  logic [PH_W-1:0] ph_q;
  logic [5:0]      bit_q;
  logic [31:0]     tx_q;
  logic [15:0]     rx_q;
  logic            err_q;
  logic            rd_q;
  logic            cmd_ready_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic            mdc_q;
  logic            mdio_o_q;
  logic            mdio_t_q;

  logic [31:0]     frame_d;
  logic            last_bit_d;
  logic            accept_d;

  // Frame after the preamble. Released bits of a read carry ones so mdio_o
  // idles high while the PHY owns the line.
  assign frame_d = {2'b01,
                    cmd_write ? 2'b01 : 2'b10,
                    cmd_phy_addr,
                    cmd_reg_addr,
                    cmd_write ? 2'b10 : 2'b11,
                    cmd_write ? cmd_wdata : 16'hFFFF};

  assign last_bit_d = (state_q == S_DATA) && (bit_q == 6'd0);
  assign accept_d   = cmd_valid && cmd_ready_q;

  // Frame sequencer: bit timing, shifting, sampling and the response pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      bit_q       <= 6'd0;
      tx_q        <= 32'h0000_0000;
      rx_q        <= 16'h0000;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          mdc_q       <= 1'b0;
          mdio_o_q    <= 1'b1;
          mdio_t_q    <= 1'b1;
          if (accept_d) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rd_q        <= !cmd_write;
            err_q       <= 1'b0;
            rx_q        <= 16'h0000;
            ph_q        <= PH_LAST;
            mdio_t_q    <= 1'b0;
            if (PREAMBLE_EN != 0) begin
              state_q  <= S_PRE;
              bit_q    <= 6'd31;
              mdio_o_q <= 1'b1;
              tx_q     <= frame_d;
            end else begin
              state_q  <= S_HDR;
              bit_q    <= 6'd13;
              mdio_o_q <= frame_d[31];
              tx_q     <= {frame_d[30:0], 1'b0};
            end
          end
        end
        default: begin
          if (ph_q == '0) begin
            // Bit boundary: mdc falls and the next bit is presented.
            ph_q  <= PH_LAST;
            mdc_q <= 1'b0;
            if (bit_q != 6'd0) begin
              bit_q <= bit_q - 6'd1;
              if (state_q != S_PRE) begin
                mdio_o_q <= tx_q[31];
                tx_q     <= {tx_q[30:0], 1'b0};
              end
            end else begin
              mdio_o_q <= tx_q[31];
              tx_q     <= {tx_q[30:0], 1'b0};
              case (state_q)
                S_PRE: begin
                  state_q <= S_HDR;
                  bit_q   <= 6'd13;
                end
                S_HDR: begin
                  state_q  <= S_TA;
                  bit_q    <= 6'd1;
                  mdio_t_q <= rd_q;
                end
                S_TA: begin
                  state_q <= S_DATA;
                  bit_q   <= 6'd15;
                end
                default: begin
                  // End of DATA: back to idle with cmd_ready already up so a
                  // new command can be taken in the first idle cycle.
                  state_q     <= S_IDLE;
                  bit_q       <= 6'd0;
                  mdio_o_q    <= 1'b1;
                  mdio_t_q    <= 1'b1;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                end
              endcase
            end
          end else begin
            ph_q <= ph_q - PH_ONE;
            if (ph_q == PH_RISE) begin
              mdc_q <= 1'b1;
              if (state_q == S_TA && bit_q == 6'd0) begin
                err_q <= mdio_i;
              end
              if (state_q == S_DATA) begin
                rx_q <= {rx_q[14:0], mdio_i};
              end
            end
            // Response lands in the final clk cycle of the final bit.
            if (ph_q == PH_ONE && last_bit_d) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_q ? rx_q : 16'h0000;
              rsp_err_q   <= rd_q & err_q;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: one instance with preamble (CLK_DIV=4) and
// one without (CLK_DIV=2), selected by sel for stimulus and observation.
module tb_mdio_master;

  localparam int D1 = 4;
  localparam int D2 = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = 5'd0;
  logic [4:0]  cmd_reg_addr = 5'd0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        mdio_i = 1'b1;

  logic        cmd_valid1, cmd_valid2;
  logic        cmd_ready1, rsp_valid1, rsp_err1, busy1, mdc1, mdio_o1, mdio_t1;
  logic        cmd_ready2, rsp_valid2, rsp_err2, busy2, mdc2, mdio_o2, mdio_t2;
  logic [15:0] rsp_rdata1, rsp_rdata2;

  logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_busy, m_mdc, m_mdio_o, m_mdio_t;
  logic [15:0] m_rsp_rdata;

  assign cmd_valid1  = cmd_valid & ~sel;
  assign cmd_valid2  = cmd_valid & sel;
  assign m_cmd_ready = sel ? cmd_ready2 : cmd_ready1;
  assign m_rsp_valid = sel ? rsp_valid2 : rsp_valid1;
  assign m_rsp_rdata = sel ? rsp_rdata2 : rsp_rdata1;
  assign m_rsp_err   = sel ? rsp_err2   : rsp_err1;
  assign m_busy      = sel ? busy2      : busy1;
  assign m_mdc       = sel ? mdc2       : mdc1;
  assign m_mdio_o    = sel ? mdio_o2    : mdio_o1;
  assign m_mdio_t    = sel ? mdio_t2    : mdio_t1;

  mdio_master #(.CLK_DIV(D1), .PREAMBLE_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1),
    .mdc(mdc1), .mdio_o(mdio_o1), .mdio_t(mdio_t1), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(D2), .PREAMBLE_EN(0)) dut_np (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
    .mdc(mdc2), .mdio_o(mdio_o2), .mdio_t(mdio_t2), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_cmd
  logic [63:0] got_o, got_t;
  int          n_rise, first_rise_k, first_rise_p, last_rise_p;
  bit          acc_ok, rsp_seen;
  int          rsp_lat, acc_wait, busy_bad, ready_bad;
  logic [15:0] cap_rdata;
  logic        cap_err;
  logic        ab_mdc, ab_t, ab_rv, ab_busy, ab_rdy;
  logic        nxt_wr;
  logic [4:0]  nxt_pa, nxt_ra;
  logic [15:0] nxt_wd;

  // PHY model: value it puts on MDIO for frame bit n (pull-up when silent).
  function automatic logic phy_bit(input int n, input int off, input bit on, input logic [15:0] pd);
    if (!on) return 1'b1;
    if (n == off + 15) return 1'b0;
    if (n >= off + 16 && n < off + 32) return pd[off + 31 - n];
    return 1'b1;
  endfunction

  // Presents one command and records the MDIO bit stream at mdc rising edges,
  // busy/ready behaviour and the response. Called and returns at a negedge.
  task automatic run_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit phy_on, input logic [15:0] pd,
                         input bit keep_valid, input int abort_after);
    int   nb, dv, off, budget;
    logic prev;
    bit   aborted;
    nb = sel ? 32 : 64;
    dv = sel ? D2 : D1;
    off = sel ? 0 : 32;
    budget = 2 * dv * nb + 20;
    got_o = '0; got_t = '0; n_rise = 0;
    first_rise_k = -1; first_rise_p = -1; last_rise_p = -1;
    rsp_seen = 0; rsp_lat = -1; busy_bad = 0; ready_bad = 0; aborted = 0;
    cap_rdata = 16'h0000; cap_err = 1'b0;
    cmd_write = wr; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
    mdio_i = phy_bit(0, off, phy_on, pd);
    acc_wait = 0;
    while (m_cmd_ready !== 1'b1 && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    acc_ok = (m_cmd_ready === 1'b1);
    if (!acc_ok) begin
      cmd_valid = 1'b0;
      return;
    end
    prev = m_mdc;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep_valid) begin
          cmd_write = nxt_wr; cmd_phy_addr = nxt_pa; cmd_reg_addr = nxt_ra; cmd_wdata = nxt_wd;
        end else begin
          cmd_valid = 1'b0;
          cmd_write = ~wr; cmd_phy_addr = ~pa; cmd_reg_addr = ~ra; cmd_wdata = ~wd;
        end
      end
      if (aborted && !resetn) resetn = 1'b1;
      if (!rsp_seen && !aborted) begin
        if (m_busy !== 1'b1) busy_bad++;
        if (m_cmd_ready !== 1'b0) ready_bad++;
      end
      if (m_mdc === 1'b1 && prev === 1'b0 && n_rise < 64) begin
        got_o[63 - n_rise] = m_mdio_o;
        got_t[63 - n_rise] = m_mdio_t;
        if (n_rise == 0) begin
          first_rise_k = k;
          first_rise_p = pcyc;
        end
        last_rise_p = pcyc;
        n_rise++;
      end
      prev = m_mdc;
      if (m_rsp_valid === 1'b1 && !rsp_seen) begin
        rsp_seen = 1;
        rsp_lat = k;
        cap_rdata = m_rsp_rdata;
        cap_err = m_rsp_err;
      end
      mdio_i = phy_bit(n_rise, off, phy_on, pd);
      if (abort_after > 0 && !aborted && n_rise == abort_after) begin
        aborted = 1;
        resetn = 1'b0;
        #1;
        ab_mdc = m_mdc; ab_t = m_mdio_t; ab_rv = m_rsp_valid; ab_busy = m_busy; ab_rdy = m_cmd_ready;
        prev = m_mdc;
      end
      if (rsp_seen) break;
    end
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready1 !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid1); end
    checks++; if (rsp_rdata1 !== 16'h0000) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0000", rsp_rdata1); end
    checks++; if (rsp_err1 !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err1); end
    checks++; if ({mdc1, mdio_t1, mdio_o1} !== 3'b011) begin errors++; $display("FAIL rst_pins: got mdc/t/o=%b expected 011", {mdc1, mdio_t1, mdio_o1}); end
    resetn = 1'b1;
    checks++; if (cmd_ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready_early: got %b expected 0", cmd_ready1); end
    @(negedge clk);
    checks++; if (cmd_ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b expected 1", cmd_ready1); end
    checks++; if (cmd_ready2 !== 1'b1) begin errors++; $display("FAIL rst_ready_rise_np: got %b expected 1", cmd_ready2); end
  endtask

  task automatic test_write();
    sel = 1'b0;
    run_cmd(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000, 1'b0, 0);
    checks++; if (!acc_ok || !rsp_seen) begin errors++; $display("FAIL wr_handshake: got acc=%0d rsp=%0d expected 1 1", acc_ok, rsp_seen); end
    checks++; if (rsp_lat !== 512) begin errors++; $display("FAIL wr_latency: got %0d expected 512", rsp_lat); end
    checks++; if (n_rise !== 64) begin errors++; $display("FAIL wr_bits: got %0d expected 64", n_rise); end
    checks++; if (first_rise_k !== D1 + 1) begin errors++; $display("FAIL wr_first_rise: got %0d expected %0d", first_rise_k, D1 + 1); end
    checks++;
    if (got_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140}) begin
      errors++; $display("FAIL wr_stream: got %h expected %h", got_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    end
    checks++; if (got_t !== 64'h0) begin errors++; $display("FAIL wr_mdio_t: got %h expected 0", got_t); end
    checks++; if (cap_rdata !== 16'h0000 || cap_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got %h/%b expected 0000/0", cap_rdata, cap_err); end
    checks++; if (busy_bad != 0 || ready_bad != 0) begin errors++; $display("FAIL wr_busy_ready: got busy_bad=%0d ready_bad=%0d expected 0 0", busy_bad, ready_bad); end
  endtask

  task automatic test_read();
    sel = 1'b0;
    run_cmd(1'b0, 5'd2, 5'd2, 16'h0000, 1'b1, 16'h0141, 1'b0, 0);
    checks++; if (rsp_lat !== 512) begin errors++; $display("FAIL rd_latency: got %0d expected 512", rsp_lat); end
    checks++; if (cap_rdata !== 16'h0141) begin errors++; $display("FAIL rd_data: got %h expected 0141", cap_rdata); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", cap_err); end
    checks++;
    if (got_o[63:18] !== {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd2, 5'd2}) begin
      errors++; $display("FAIL rd_header: got %h expected %h", got_o[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd2, 5'd2});
    end
    checks++; if (got_t !== 64'h0000_0000_0003_FFFF) begin errors++; $display("FAIL rd_mdio_t: got %h expected 000000000003ffff", got_t); end
    checks++; if (busy_bad != 0 || ready_bad != 0) begin errors++; $display("FAIL rd_busy_ready: got busy_bad=%0d ready_bad=%0d expected 0 0", busy_bad, ready_bad); end
    repeat (3) @(negedge clk);
    checks++; if (rsp_rdata1 !== 16'h0141) begin errors++; $display("FAIL rd_hold: got %h expected 0141", rsp_rdata1); end
    checks++;
    if ({mdc1, mdio_t1, mdio_o1, busy1, cmd_ready1, rsp_valid1} !== 6'b011010) begin
      errors++; $display("FAIL rd_idle: got mdc/t/o/busy/ready/rv=%b expected 011010", {mdc1, mdio_t1, mdio_o1, busy1, cmd_ready1, rsp_valid1});
    end
  endtask

  task automatic test_no_phy();
    sel = 1'b0;
    run_cmd(1'b0, 5'd7, 5'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    checks++; if (rsp_lat !== 512) begin errors++; $display("FAIL nophy_latency: got %0d expected 512", rsp_lat); end
    checks++; if (cap_rdata !== 16'hFFFF || cap_err !== 1'b1) begin errors++; $display("FAIL nophy_rsp: got %h/%b expected ffff/1", cap_rdata, cap_err); end
  endtask

  task automatic test_back_to_back();
    int lr1;
    sel = 1'b0;
    nxt_wr = 1'b0; nxt_pa = 5'd5; nxt_ra = 5'd6; nxt_wd = 16'h0000;
    run_cmd(1'b1, 5'd3, 5'd4, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 0);
    lr1 = last_rise_p;
    checks++; if (rsp_lat !== 512) begin errors++; $display("FAIL b2b_lat1: got %0d expected 512", rsp_lat); end
    checks++;
    if (got_o !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5A5}) begin
      errors++; $display("FAIL b2b_stream1: got %h expected %h", got_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5A5});
    end
    checks++; if (ready_bad != 0 || m_cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got ready_bad=%0d ready_at_rsp=%b expected 0 0", ready_bad, m_cmd_ready); end
    run_cmd(1'b0, 5'd5, 5'd6, 16'h0000, 1'b1, 16'h1234, 1'b0, 0);
    checks++; if (acc_wait !== 1) begin errors++; $display("FAIL b2b_accept: got %0d cycles after rsp expected 1", acc_wait); end
    checks++; if (first_rise_p - lr1 !== 2 * D1 + 1) begin errors++; $display("FAIL b2b_mdc_gap: got %0d expected %0d", first_rise_p - lr1, 2 * D1 + 1); end
    checks++;
    if (got_o[63:18] !== {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd5, 5'd6}) begin
      errors++; $display("FAIL b2b_header2: got %h expected %h", got_o[63:18], {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd5, 5'd6});
    end
    checks++; if (cap_rdata !== 16'h1234 || cap_err !== 1'b0) begin errors++; $display("FAIL b2b_rsp2: got %h/%b expected 1234/0", cap_rdata, cap_err); end
  endtask

  task automatic test_reset_abort();
    sel = 1'b0;
    run_cmd(1'b0, 5'd2, 5'd2, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 51);
    checks++; if (ab_mdc !== 1'b0 || ab_t !== 1'b1) begin errors++; $display("FAIL abort_pins: got mdc=%b t=%b expected 0 1", ab_mdc, ab_t); end
    checks++; if ({ab_rv, ab_busy, ab_rdy} !== 3'b000) begin errors++; $display("FAIL abort_ctl: got rv/busy/ready=%b expected 000", {ab_rv, ab_busy, ab_rdy}); end
    checks++; if (rsp_seen || n_rise !== 51) begin errors++; $display("FAIL abort_quiet: got rsp=%0d rises=%0d expected 0 51", rsp_seen, n_rise); end
    repeat (2) @(negedge clk);
    run_cmd(1'b0, 5'd2, 5'd2, 16'h0000, 1'b1, 16'h0141, 1'b0, 0);
    checks++; if (rsp_lat !== 512 || n_rise !== 64) begin errors++; $display("FAIL abort_next_frame: got lat=%0d bits=%0d expected 512 64", rsp_lat, n_rise); end
    checks++; if (cap_rdata !== 16'h0141 || cap_err !== 1'b0) begin errors++; $display("FAIL abort_next_rsp: got %h/%b expected 0141/0", cap_rdata, cap_err); end
  endtask

  task automatic test_no_preamble();
    sel = 1'b1;
    @(negedge clk);
    run_cmd(1'b1, 5'h1F, 5'h15, 16'h8001, 1'b0, 16'h0000, 1'b0, 0);
    checks++; if (rsp_lat !== 128) begin errors++; $display("FAIL np_latency: got %0d expected 128", rsp_lat); end
    checks++; if (n_rise !== 32) begin errors++; $display("FAIL np_bits: got %0d expected 32", n_rise); end
    checks++; if (first_rise_k !== D2 + 1 || got_o[63] !== 1'b0) begin errors++; $display("FAIL np_first_bit: got k=%0d bit=%b expected %0d 0", first_rise_k, got_o[63], D2 + 1); end
    checks++;
    if (got_o[63:32] !== {2'b01, 2'b01, 5'h1F, 5'h15, 2'b10, 16'h8001}) begin
      errors++; $display("FAIL np_stream: got %h expected %h", got_o[63:32], {2'b01, 2'b01, 5'h1F, 5'h15, 2'b10, 16'h8001});
    end
    checks++; if (got_t[63:32] !== 32'h0) begin errors++; $display("FAIL np_mdio_t: got %h expected 0", got_t[63:32]); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_back_to_back();
    test_reset_abort();
    test_no_preamble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
